// File: rtl/seq_match_monitor.sv
// seq_match_monitor: counts match pulses from the serial sequence detector,
// raises a level interrupt at a programmable threshold (held until acked),
// flags counter saturation, and optionally measures match-to-match spacing.
// Optional feature macro: MATCH_INTERVAL_EN (interval timer and outputs).
module seq_match_monitor #(
  parameter int CNT_W = 8,
  parameter int IVL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             match_in,
  input  logic             enable,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  output logic             ovf,
  output logic             ivl_valid,
  output logic [IVL_W-1:0] last_ivl,
  output logic [IVL_W-1:0] min_ivl
);

  typedef enum logic [1:0] {
    DISABLED,
    ARMED,
    ALERT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ovf_q, ovf_nxt;

  // State, counter and overflow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DISABLED;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // Next-state and next-count: clr > enable low > irq_ack > match_in
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    ovf_nxt   = ovf_q;
    if (clr) begin
      state_nxt = enable ? ARMED : DISABLED;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (!enable) begin
      state_nxt = DISABLED;
    end else begin
      case (state)
        DISABLED: state_nxt = ARMED;
        ARMED, ALERT: begin
          if (state == ALERT && irq_ack) begin
            // Ack restarts the count; a match in the ack cycle counts as 1
            // and the restarted count is compared against thresh again.
            cnt_nxt   = match_in ? CNT_W'(1) : '0;
            state_nxt = (thresh != '0 && cnt_nxt >= thresh) ? ALERT : ARMED;
          end else if (match_in) begin
            if (cnt_q == CNT_MAX) ovf_nxt = 1'b1;
            else                  cnt_nxt = cnt_q + 1'b1;
            if (thresh != '0 && cnt_nxt >= thresh) state_nxt = ALERT;
          end
        end
        default: state_nxt = DISABLED;
      endcase
    end
  end

  // Outputs: irq is a pure decode of the registered state
  always_comb begin
    irq       = (state == ALERT);
    match_cnt = cnt_q;
    ovf       = ovf_q;
  end

`ifdef MATCH_INTERVAL_EN
  logic [IVL_W-1:0] timer_q, last_q, min_q;
  logic             valid_q;
  logic             running;
  logic             counted;

  // A match is counted whenever the monitor is active (ack cycles included)
  always_comb begin
    running = !clr && enable && (state == ARMED || state == ALERT);
    counted = running && match_in;
  end

  // Interval timer; it idles at 0 until the first match starts it, so the
  // first match after reset/clr never produces a capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      last_q  <= '0;
      min_q   <= '1;
      valid_q <= 1'b0;
    end else if (clr) begin
      timer_q <= '0;
      last_q  <= '0;
      min_q   <= '1;
      valid_q <= 1'b0;
    end else if (counted) begin
      timer_q <= IVL_W'(1);
      if (timer_q != '0) begin
        last_q  <= timer_q;
        valid_q <= 1'b1;
        if (timer_q < min_q) min_q <= timer_q;
      end
    end else if (running && timer_q != '0 && timer_q != '1) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Interval outputs
  always_comb begin
    ivl_valid = valid_q;
    last_ivl  = last_q;
    min_ivl   = min_q;
  end
`else
  // Interval outputs tied off when the timer is not built
  always_comb begin
    ivl_valid = 1'b0;
    last_ivl  = '0;
    min_ivl   = '0;
  end
`endif

endmodule

// File: doc/seq_match_monitor.md
Name: seq_match_monitor

Overview:
- Downstream consumer of the serial sequence detector's one-cycle match pulse (its dout).
- Counts match events and raises a level interrupt when a programmable threshold is reached, held until acknowledged.
- Optionally measures the spacing between consecutive matches for debug and characterisation.
- Sits between the detector and the control/status register block.

Parameters:
- CNT_W, 8, width of the match counter and of the threshold.
- IVL_W, 16, width of the interval timer and interval outputs.

Ports:
- clk  input  1  rising-edge clock, same domain as the detector.
- reset  input  1  asynchronous, active-high; clears all state.
- match_in  input  1  match pulse from the detector; sampled every cycle; may be high on consecutive cycles.
- enable  input  1  monitor enable.
- clr  input  1  synchronous clear of counter, flags and interval state.
- thresh  input  CNT_W  alert threshold; 0 disables alerting.
- irq_ack  input  1  interrupt acknowledge, sampled each cycle.
- match_cnt  output  CNT_W  current match count, saturating.
- irq  output  1  alert interrupt, level.
- ovf  output  1  sticky; set on an increment attempt at the all-ones count.
- ivl_valid  output  1  high once at least one interval has been captured.
- last_ivl  output  IVL_W  cycles between the last two matches.
- min_ivl  output  IVL_W  smallest interval since reset or clr.

Behaviour:
- Reset values:
  - match_cnt=0, irq=0, ovf=0, ivl_valid=0, last_ivl=0.
  - min_ivl = all-ones; interval timer = 0.
  - State = DISABLED.
- Registered outputs: every response appears on the edge after the input that caused it (1-cycle latency).
- Priority, highest first: reset, clr, enable low, irq_ack, match_in.
- States:
  - DISABLED: match_in is ignored; match_cnt and ovf hold; irq=0; interval timer holds. enable=1 -> ARMED.
  - ARMED: each match_in=1 cycle increments match_cnt. If thresh!=0 and the new count >= thresh -> ALERT, with irq=1 on the same edge.
  - ALERT: irq=1. Matches keep counting.
    - irq_ack=1 -> ARMED; irq=0; match_cnt <= (match_in ? 1 : 0). That post-ack count is re-checked against thresh, so thresh=1 with match_in=1 re-enters ALERT.
  - From ARMED or ALERT, enable=0 -> DISABLED; irq=0; count holds.
- Saturation: an increment at match_cnt = all-ones keeps the count at all-ones and sets ovf.
- ovf is cleared only by reset or clr; irq_ack does not clear it.
- thresh changed while in ALERT: irq stays high until acked.
- thresh=0: the block never enters ALERT.
- clr=1 (synchronous):
  - match_cnt=0, ovf=0, irq=0, ivl_valid=0, last_ivl=0, min_ivl=all-ones, timer=0.
  - Next state = enable ? ARMED : DISABLED.
  - A match in the clr cycle is discarded.
- irq_ack while not in ALERT: no effect.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.

Optional Feature:
- Macro: MATCH_INTERVAL_EN.
- Defined:
  - The interval timer runs only in ARMED or ALERT.
  - On a counted match, the timer loads 1.
  - On any other enabled cycle, the timer increments, saturating at all-ones.
  - At a counted match with the timer != 0 (a previous match exists):
    - last_ivl <= timer, ivl_valid <= 1;
    - min_ivl <= min(min_ivl, timer).
  - The first match after reset or clr only starts the timer.
  - Result: matches at cycles t and t+k give last_ivl = k.
- Undefined: the timer is not built; ivl_valid=0, last_ivl=0, min_ivl=0 as constants; ports remain present.

Test Plan:
- Reset then enable=1, thresh=3; pulse match_in at cycles 5, 8, 11 -> match_cnt 1, 2, 3; irq rises the edge after cycle 11 and holds.
- In ALERT, irq_ack=1 with match_in=0 -> irq=0 and match_cnt=0 the next cycle. Repeat with irq_ack and match_in both 1 -> match_cnt=1, irq=0 (thresh=3).
- CNT_W=8, thresh=0, 257 consecutive match pulses -> match_cnt=255, ovf=1, irq never asserted. Then clr -> match_cnt=0, ovf=0.
- enable=0 during ALERT -> irq=0 next cycle; match pulses ignored, count holds at 4. Re-enable -> ARMED; next match -> count 5, irq=1 (thresh=3).
- MATCH_INTERVAL_EN defined; matches at cycles 10, 13, 20, 23 -> last_ivl 3, 7, 3; min_ivl=3; ivl_valid rises after cycle 13. Undefined -> all three interval outputs stay 0.
- Assert reset asynchronously between clock edges while in ALERT with count 7 -> irq=0 and match_cnt=0 immediately; state DISABLED until enable is seen after reset release.
